sie_tx_seq: RTL and testbench

//  Packet sequencer that feeds the byte-wide full-speed transmit PHY handshake (valid/ready, one-cycle ready pulse).

---
 rtl/sie_tx_seq_if.sv | 56 +++++
 rtl/sie_tx_seq.sv | 197 +++++++++++++++++++
 tb/tb_sie_tx_seq.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sie_tx_seq_if.sv
// ----------------------------------------------------------------------------
// sie_tx_seq_if
//   Bundles every non-clock signal of the SIE transmit packet sequencer:
//   the request handshake from endpoint logic, the payload source handshake,
//   the byte-wide PHY transmit handshake and the status strobes.
//
//   Signals
//     req_valid / req_ready   packet request handshake
//     pid / with_data / data_len
//                             request fields, sampled at accept
//     data_valid / data / data_ready
//                             payload source; data_ready pulses on consumption
//     tx_valid / tx_data      byte offered to the PHY (LSB first on the line)
//     tx_ready                PHY consumed tx_data (one-cycle pulse)
//     tx_en                   PHY is driving the line (SYNC..EOP)
//     busy / done / err       status: not idle, gap expired, payload underrun
//
//   Modports
//     master  environment side (endpoint logic, data source and PHY)
//     slave   the sequencer itself
// ----------------------------------------------------------------------------
interface sie_tx_seq_if #(
    parameter int LEN_W = 10
);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       pid;
    logic             with_data;
    logic [LEN_W-1:0] data_len;
    logic             data_valid;
    logic [7:0]       data;
    logic             data_ready;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_ready;
    logic             tx_en;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output req_valid, pid, with_data, data_len,
        output data_valid, data,
        output tx_ready, tx_en,
        input  req_ready, data_ready, tx_valid, tx_data,
        input  busy, done, err
    );

    modport slave (
        input  req_valid, pid, with_data, data_len,
        input  data_valid, data,
        input  tx_ready, tx_en,
        output req_ready, data_ready, tx_valid, tx_data,
        output busy, done, err
    );
endinterface

// File: rtl/sie_tx_seq.sv
// ----------------------------------------------------------------------------
// sie_tx_seq
//   Transmit packet sequencer between SIE endpoint logic and the byte-wide
//   full-speed transmit PHY. For each accepted request it sends the PID byte,
//   then (for data packets) the payload pulled from the data source followed
//   by the inverted USB CRC16, low byte first. It then waits for the PHY to
//   release the line, holds off for GAP_CYCLES clocks and pulses done.
//   A payload underrun aborts the packet without CRC and pulses err.
//
//   Ports
//     clk_i    clock
//     rstn_i   asynchronous, active-low reset
//     bus      sie_tx_seq_if.slave (request, payload source, PHY, status)
//
//   Parameters
//     LEN_W       width of the payload length field
//     GAP_CYCLES  idle clocks after tx_en falls before done (0..255)
// ----------------------------------------------------------------------------
module sie_tx_seq #(
    parameter int LEN_W      = 10,
    parameter int GAP_CYCLES = 16
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    sie_tx_seq_if.slave  bus
);

    localparam int GAP_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_DATA,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_WAIT_EOP,
        ST_GAP
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       pid_q;
    logic             with_data_q;
    logic [LEN_W-1:0] len_q, len_nxt;
    logic [15:0]      crc_q, crc_nxt;
    logic [GAP_W-1:0] gap_q, gap_nxt;

    logic             req_ready;
    logic             busy;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             data_ready;
    logic             done;
    logic             err;

    wire accept = (state == ST_IDLE) && bus.req_valid;

    // Reflected USB CRC16 over one byte, LSB first, eight bit steps unrolled.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                               input logic [7:0]  b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ ((c[0] ^ b[i]) ? 16'hA001 : 16'h0000);
        end
        return c;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= ST_IDLE;
            pid_q       <= '0;
            with_data_q <= 1'b0;
            len_q       <= '0;
            crc_q       <= '0;
            gap_q       <= '0;
        end else begin
            state <= state_nxt;
            len_q <= len_nxt;
            crc_q <= crc_nxt;
            gap_q <= gap_nxt;
            if (accept) begin
                pid_q       <= bus.pid;
                with_data_q <= bus.with_data;
            end
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_nxt  = state;
        len_nxt    = len_q;
        crc_nxt    = crc_q;
        gap_nxt    = gap_q;
        req_ready  = 1'b0;
        busy       = 1'b1;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        data_ready = 1'b0;
        done       = 1'b0;
        err        = 1'b0;

        unique case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (bus.req_valid) begin
                    len_nxt   = bus.data_len;
                    crc_nxt   = 16'hFFFF;
                    state_nxt = ST_PID;
                end
            end

            ST_PID: begin
                tx_valid = 1'b1;
                tx_data  = {~pid_q, pid_q};
                if (bus.tx_ready) begin
                    if (!with_data_q)
                        state_nxt = ST_WAIT_EOP;
                    else if (len_q == '0)
                        state_nxt = ST_CRC_LO;
                    else
                        state_nxt = ST_DATA;
                end
            end

            ST_DATA: begin
                // Payload byte is passed straight through; the source holds it
                // stable until data_ready.
                tx_valid = 1'b1;
                tx_data  = bus.data;
                if (bus.tx_ready) begin
                    if (bus.data_valid) begin
                        data_ready = 1'b1;
                        crc_nxt    = crc16_byte(crc_q, bus.data);
                        len_nxt    = len_q - LEN_W'(1);
                        if (len_q == LEN_W'(1))
                            state_nxt = ST_CRC_LO;
                    end else begin
                        // Underrun: the PHY already took a garbage byte, so the
                        // packet is cut short and the receiver sees a bad CRC.
                        err       = 1'b1;
                        state_nxt = ST_WAIT_EOP;
                    end
                end
            end

            ST_CRC_LO: begin
                tx_valid = 1'b1;
                tx_data  = ~crc_q[7:0];
                if (bus.tx_ready)
                    state_nxt = ST_CRC_HI;
            end

            ST_CRC_HI: begin
                tx_valid = 1'b1;
                tx_data  = ~crc_q[15:8];
                if (bus.tx_ready)
                    state_nxt = ST_WAIT_EOP;
            end

            ST_WAIT_EOP: begin
                // Entered while the PHY still drives the line; leave on its fall.
                if (!bus.tx_en) begin
                    gap_nxt   = GAP_W'(GAP_CYCLES);
                    state_nxt = ST_GAP;
                end
            end

            ST_GAP: begin
                // done fires in the cycle whose decrement reaches zero, which puts
                // it GAP_CYCLES clocks after tx_en is first seen low; a zero count
                // fires on the first gap cycle.
                if (gap_q <= GAP_W'(1)) begin
                    done      = 1'b1;
                    gap_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    gap_nxt = gap_q - GAP_W'(1);
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.req_ready  = req_ready;
    assign bus.busy       = busy;
    assign bus.tx_valid   = tx_valid;
    assign bus.tx_data    = tx_data;
    assign bus.data_ready = data_ready;
    assign bus.done       = done;
    assign bus.err        = err;

endmodule

// File: tb/tb_sie_tx_seq.sv
// ----------------------------------------------------------------------------
// tb_sie_tx_seq
//   Directed bench for sie_tx_seq. The initial block plays endpoint logic,
//   payload source and PHY. Expected bytes are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_sie_tx_seq;

    localparam int LEN_W = 10;
    localparam int GAP   = 16;

    logic clk;
    logic rstn;

    int n_assert = 0;
    int n_fail   = 0;

    // Event counters sampled mid-cycle, after bench drives have settled.
    int done_seen = 0;
    int err_seen  = 0;
    int dr_seen   = 0;
    int acc_seen  = 0;

    sie_tx_seq_if #(.LEN_W(LEN_W)) bus ();

    sie_tx_seq #(
        .LEN_W      (LEN_W),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always begin
        @(negedge clk);
        #2;
        if (bus.done === 1'b1) done_seen++;
        if (bus.err === 1'b1) err_seen++;
        if (bus.data_ready === 1'b1) dr_seen++;
        if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1 && rstn === 1'b1) acc_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a request at a falling edge and withdraws it after the accept edge.
    task automatic request(input string tag, input logic [3:0] pid, input logic wd,
                           input logic [LEN_W-1:0] len);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.pid       = pid;
        bus.with_data = wd;
        bus.data_len  = len;
        #1;
        check({tag, "_req_ready"}, bus.req_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // PHY side: waits for a valid byte, checks it, and consumes it with a
    // one-cycle tx_ready pulse.
    task automatic take_byte(input string tag, input logic [7:0] exp,
                             input logic exp_dr, input logic exp_err);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.tx_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, bus.tx_valid, 1'b1);
        check({tag, "_data"}, bus.tx_data, exp);
        bus.tx_ready = 1'b1;
        bus.tx_en    = 1'b1;
        #1;
        check({tag, "_data_ready"}, bus.data_ready, exp_dr);
        check({tag, "_err"}, bus.err, exp_err);
        @(posedge clk);
        #1;
        bus.tx_ready = 1'b0;
    endtask

    // After the last byte: line stays driven briefly (EOP), then drops;
    // done must arrive exactly GAP cycles after the fall.
    task automatic finish_pkt(input string tag);
        int n;
        @(negedge clk);
        check({tag, "_eop_valid"}, bus.tx_valid, 1'b0);
        check({tag, "_eop_data"}, bus.tx_data, 8'h00);
        check({tag, "_eop_busy"}, bus.busy, 1'b1);
        check({tag, "_eop_req_ready"}, bus.req_ready, 1'b0);
        repeat (2) @(negedge clk);
        bus.tx_en = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.done !== 1'b1 && n < 100);
        check({tag, "_gap_len"}, n, GAP);
        @(negedge clk);
        check({tag, "_done_pulse"}, bus.done, 1'b0);
        check({tag, "_idle_ready"}, bus.req_ready, 1'b1);
        check({tag, "_idle_busy"}, bus.busy, 1'b0);
    endtask

    initial begin
        int base_done, base_err, base_dr, base_acc;

        rstn           = 1'b0;
        bus.req_valid  = 1'b0;
        bus.pid        = 4'h0;
        bus.with_data  = 1'b0;
        bus.data_len   = '0;
        bus.data_valid = 1'b0;
        bus.data       = 8'h00;
        bus.tx_ready   = 1'b0;
        bus.tx_en      = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_tx_valid", bus.tx_valid, 1'b0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_data_ready", bus.data_ready, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_err", bus.err, 1'b0);
        rstn = 1'b1;

        // ACK: PID only
        base_done = done_seen;
        request("ack", 4'h2, 1'b0, '0);
        take_byte("ack_pid", 8'hD2, 1'b0, 1'b0);
        finish_pkt("ack");
        check("ack_done_count", done_seen - base_done, 1);

        // DATA0 with zero-length payload: CRC of nothing is FFFF, inverted 0000
        request("d0", 4'h3, 1'b1, 10'd0);
        take_byte("d0_pid", 8'hC3, 1'b0, 1'b0);
        take_byte("d0_crc_lo", 8'h00, 1'b0, 1'b0);
        take_byte("d0_crc_hi", 8'h00, 1'b0, 1'b0);
        finish_pkt("d0");

        // DATA1 "123456789": USB CRC16 check value B4C8, sent low byte first
        base_dr = dr_seen;
        request("d1", 4'hB, 1'b1, 10'd9);
        take_byte("d1_pid", 8'h4B, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            bus.data_valid = 1'b1;
            bus.data       = 8'h31 + 8'(k);
            take_byte($sformatf("d1_pl%0d", k), 8'h31 + 8'(k), 1'b1, 1'b0);
        end
        bus.data_valid = 1'b0;
        bus.data       = 8'h00;
        take_byte("d1_crc_lo", 8'hC8, 1'b0, 1'b0);
        take_byte("d1_crc_hi", 8'hB4, 1'b0, 1'b0);
        finish_pkt("d1");
        check("d1_data_ready_count", dr_seen - base_dr, 9);

        // Underrun on the third of four payload bytes
        base_err  = err_seen;
        base_done = done_seen;
        request("ur", 4'hB, 1'b1, 10'd4);
        take_byte("ur_pid", 8'h4B, 1'b0, 1'b0);
        bus.data_valid = 1'b1;
        bus.data       = 8'h10;
        take_byte("ur_pl0", 8'h10, 1'b1, 1'b0);
        bus.data = 8'h20;
        take_byte("ur_pl1", 8'h20, 1'b1, 1'b0);
        bus.data_valid = 1'b0;
        bus.data       = 8'h30;
        take_byte("ur_pl2", 8'h30, 1'b0, 1'b1);
        bus.data = 8'h00;
        finish_pkt("ur");
        check("ur_err_count", err_seen - base_err, 1);
        check("ur_done_count", done_seen - base_done, 1);

        // Back-to-back: request held high across two packets
        base_acc = acc_seen;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.pid       = 4'h2;
        bus.with_data = 1'b0;
        @(posedge clk);
        #1;
        bus.pid = 4'hA;
        take_byte("b2b_first", 8'hD2, 1'b0, 1'b0);
        check("b2b_accepts_first", acc_seen - base_acc, 1);
        finish_pkt("b2b_a");
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        take_byte("b2b_second", 8'h5A, 1'b0, 1'b0);
        check("b2b_accepts_second", acc_seen - base_acc, 2);
        finish_pkt("b2b_b");

        // Reset in the middle of the payload
        base_done = done_seen;
        base_err  = err_seen;
        request("rm", 4'h3, 1'b1, 10'd4);
        take_byte("rm_pid", 8'hC3, 1'b0, 1'b0);
        bus.data_valid = 1'b1;
        bus.data       = 8'hA5;
        take_byte("rm_pl0", 8'hA5, 1'b1, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rm_tx_valid", bus.tx_valid, 1'b0);
        check("rm_req_ready", bus.req_ready, 1'b1);
        check("rm_busy", bus.busy, 1'b0);
        check("rm_tx_data", bus.tx_data, 8'h00);
        repeat (2) @(negedge clk);
        bus.tx_en      = 1'b0;
        bus.data_valid = 1'b0;
        bus.data       = 8'h00;
        rstn           = 1'b1;
        repeat (GAP + 4) @(negedge clk);
        check("rm_no_done", done_seen - base_done, 0);
        check("rm_no_err", err_seen - base_err, 0);

        // Next packet after reset is sent correctly
        request("pr", 4'h3, 1'b1, 10'd0);
        take_byte("pr_pid", 8'hC3, 1'b0, 1'b0);
        take_byte("pr_crc_lo", 8'h00, 1'b0, 1'b0);
        take_byte("pr_crc_hi", 8'h00, 1'b0, 1'b0);
        finish_pkt("pr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
